// File: rtl/hv_pwm_msg_sched_pkg.sv
// Package for the HV PWM message scheduler: shared encodings plus frame pattern helpers.
package hv_pwm_msg_sched_pkg;

`include "hv_param.svh"

    // Symbol pattern, first symbol in the MSB, left-aligned.
    function automatic logic [HV_PAT_W-1:0] hv_pattern(input hv_frame_e ft,
                                                       input logic [2:0] code);
        logic [HV_PAT_W-1:0] pat;
        case (ft)
            FrIntb1: pat = 6'b101000;
            FrIntb0: pat = 6'b100000;
            FrFlt:   pat = {2'b10, code, ^code};
            default: pat = 6'b100000;
        endcase
        return pat;
    endfunction

    function automatic logic [HV_IDX_W-1:0] hv_len(input hv_frame_e ft);
        logic [HV_IDX_W-1:0] len;
        case (ft)
            FrIntb1: len = 3'd3;
            FrIntb0: len = 3'd1;
            FrFlt:   len = 3'd6;
            default: len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/hv_param.svh
// Shared defaults and encodings for the HV PWM message scheduler.
// Included only by hv_pwm_msg_sched_pkg so every user sees one copy through the package.
localparam int unsigned HV_EXT_CYC_DEF = 8;
localparam int unsigned HV_GAP_CYC_DEF = 4;
localparam int unsigned HV_PAT_W       = 6;
localparam int unsigned HV_IDX_W       = 3;

typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
} hv_state_e;

typedef enum logic [1:0] {
    FrIntb1,
    FrIntb0,
    FrFlt
} hv_frame_e;

// File: rtl/hv_pwm_msg_sched_sym.sv
// Symbol serializer: shifts a loaded pattern out MSB first, each symbol held EXT_CYC_NUM cycles.
// o_done is high during the final cycle of the final symbol.
module hv_pwm_sym_ser
    import hv_pwm_msg_sched_pkg::*;
#(
    parameter int unsigned EXT_CYC_NUM = HV_EXT_CYC_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [HV_PAT_W-1:0] i_pat,
    input  logic [HV_IDX_W-1:0] i_len,
    output logic                o_sym,
    output logic                o_done
);

    logic [HV_PAT_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [HV_IDX_W-1:0] idx_q, idx_d;
    logic [HV_IDX_W-1:0] last_q, last_d;
    logic                active_q, active_d;
    logic                hold_end;
    logic                last_sym;

    assign hold_end = (hold_q == CNT_W'(EXT_CYC_NUM - 1));
    assign last_sym = (idx_q == last_q);
    assign o_done   = active_q && hold_end && last_sym;
    assign o_sym    = sh_q[HV_PAT_W-1];

    always_comb begin
        sh_d     = sh_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        last_d   = last_q;
        active_d = active_q;
        if (i_load) begin
            sh_d     = i_pat;
            hold_d   = '0;
            idx_d    = '0;
            last_d   = i_len - HV_IDX_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (hold_end) begin
                hold_d = '0;
                if (last_sym) begin
                    active_d = 1'b0;
                end else begin
                    idx_d = idx_q + HV_IDX_W'(1);
                    sh_d  = {sh_q[HV_PAT_W-2:0], 1'b0};
                end
            end else begin
                hold_d = hold_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_q     <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            active_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/hv_pwm_msg_sched.sv
// HV PWM message scheduler: arbitrates INTB / fault / watchdog frames and overlays them on the
// live PWM gate wave, which is passed through whenever no frame is being sent.
module hv_pwm_msg_sched
    import hv_pwm_msg_sched_pkg::*;
#(
    parameter int unsigned EXT_CYC_NUM = HV_EXT_CYC_DEF,
    parameter int unsigned GAP_CYC_NUM = HV_GAP_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hv_pwm_gwave,
    input  logic       i_intb_req,
    input  logic       i_intb_lvl,
    input  logic       i_wdg_req,
    input  logic       i_flt_req,
    input  logic [2:0] i_flt_code,
    output logic       o_hv_pwm_tx,
    output logic       o_busy,
    output logic       o_flt_ack,
    output logic       o_flt_ovr
);

    localparam int unsigned CNT_MAX = (EXT_CYC_NUM > GAP_CYC_NUM) ? EXT_CYC_NUM : GAP_CYC_NUM;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    hv_state_e           state_q, state_d;
    hv_frame_e           ftype_q, ftype_d;
    logic                intb_pend_q, intb_pend_d;
    logic                flt_pend_q, flt_pend_d;
    logic                wdg_pend_q, wdg_pend_d;
    logic                last_lvl_q;
    logic [2:0]          flt_code_q;
    logic                g_lock_q, g_lock_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic                tx_q, tx_d;
    logic                ovr_q;
    logic                grant_intb, grant_flt, grant_wdg;
    logic                ser_load, ser_sym, ser_done;
    logic [HV_PAT_W-1:0] ser_pat;
    logic [HV_IDX_W-1:0] ser_len;

    always_comb begin
        state_d    = state_q;
        ftype_d    = ftype_q;
        g_lock_d   = g_lock_q;
        gap_d      = gap_q;
        tx_d       = i_hv_pwm_gwave;
        ser_load   = 1'b0;
        grant_intb = 1'b0;
        grant_flt  = 1'b0;
        grant_wdg  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Watchdog resends the last INTB level, so it shares the INTB patterns.
                if (intb_pend_q) begin
                    grant_intb = 1'b1;
                    ftype_d    = last_lvl_q ? FrIntb1 : FrIntb0;
                end else if (flt_pend_q) begin
                    grant_flt = 1'b1;
                    ftype_d   = FrFlt;
                end else if (wdg_pend_q) begin
                    grant_wdg = 1'b1;
                    ftype_d   = last_lvl_q ? FrIntb1 : FrIntb0;
                end
                if (intb_pend_q || flt_pend_q || wdg_pend_q) begin
                    state_d  = StSend;
                    ser_load = 1'b1;
                    g_lock_d = i_hv_pwm_gwave;
                end
            end
            StSend: begin
                tx_d = g_lock_q ^ ser_sym;
                if (ser_done) begin
                    state_d = StGap;
                    gap_d   = '0;
                end
            end
            StGap: begin
                if (gap_q == CNT_W'(GAP_CYC_NUM - 1)) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A request coinciding with its own grant keeps the flag set.
    assign intb_pend_d = (intb_pend_q & ~grant_intb) | i_intb_req;
    assign flt_pend_d  = (flt_pend_q & ~grant_flt) | i_flt_req;
    assign wdg_pend_d  = (wdg_pend_q & ~grant_wdg) | i_wdg_req;

    assign ser_pat = hv_pattern(ftype_d, flt_code_q);
    assign ser_len = hv_len(ftype_d);

    hv_pwm_sym_ser #(
        .EXT_CYC_NUM (EXT_CYC_NUM),
        .CNT_W       (CNT_W)
    ) u_sym_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (ser_load),
        .i_pat   (ser_pat),
        .i_len   (ser_len),
        .o_sym   (ser_sym),
        .o_done  (ser_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            ftype_q     <= FrIntb1;
            intb_pend_q <= 1'b0;
            flt_pend_q  <= 1'b0;
            wdg_pend_q  <= 1'b0;
            last_lvl_q  <= 1'b1;
            flt_code_q  <= 3'b000;
            g_lock_q    <= 1'b0;
            gap_q       <= '0;
            tx_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ftype_q     <= ftype_d;
            intb_pend_q <= intb_pend_d;
            flt_pend_q  <= flt_pend_d;
            wdg_pend_q  <= wdg_pend_d;
            g_lock_q    <= g_lock_d;
            gap_q       <= gap_d;
            tx_q        <= tx_d;
            ovr_q       <= i_flt_req & flt_pend_q;
            if (i_intb_req) begin
                last_lvl_q <= i_intb_lvl;
            end
            if (i_flt_req) begin
                flt_code_q <= i_flt_code;
            end
        end
    end

    assign o_hv_pwm_tx = tx_q;
    assign o_busy      = (state_q != StIdle);
    assign o_flt_ack   = (state_q == StSend) && ser_done && (ftype_q == FrFlt);
    assign o_flt_ovr   = ovr_q;

endmodule

// File: tb/tb_hv_pwm_msg_sched.sv
// Directed bench for hv_pwm_msg_sched: per-cycle expected tx/busy pushed to a scoreboard queue
// when stimulus is driven, popped and checked on each falling clock edge.
module tb_hv_pwm_msg_sched;

    localparam int EXT = 8;
    localparam int GAP = 4;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_hv_pwm_gwave;
    logic       i_intb_req;
    logic       i_intb_lvl;
    logic       i_wdg_req;
    logic       i_flt_req;
    logic [2:0] i_flt_code;
    logic       o_hv_pwm_tx;
    logic       o_busy;
    logic       o_flt_ack;
    logic       o_flt_ovr;

    typedef struct packed {
        logic tx;
        logic busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_cnt  = 0;
    int   ovr_cnt  = 0;

    hv_pwm_msg_sched #(
        .EXT_CYC_NUM (EXT),
        .GAP_CYC_NUM (GAP)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_hv_pwm_gwave (i_hv_pwm_gwave),
        .i_intb_req     (i_intb_req),
        .i_intb_lvl     (i_intb_lvl),
        .i_wdg_req      (i_wdg_req),
        .i_flt_req      (i_flt_req),
        .i_flt_code     (i_flt_code),
        .o_hv_pwm_tx    (o_hv_pwm_tx),
        .o_busy         (o_busy),
        .o_flt_ack      (o_flt_ack),
        .o_flt_ovr      (o_flt_ovr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [5:0] flt_pat(input logic [2:0] code);
        return {2'b10, code, code[2] ^ code[1] ^ code[0]};
    endfunction

    // Frame seen from the cycle after the request: 2 lead cycles, symbols, GAP-1 busy tail.
    task automatic push_frame(input logic gw, input logic [5:0] pat, input int len);
        exp_t e;
        e.tx   = gw;
        e.busy = 1'b0;
        sb_q.push_back(e);
        e.busy = 1'b1;
        sb_q.push_back(e);
        for (int s = 0; s < len; s++) begin
            for (int c = 0; c < EXT; c++) begin
                e.tx = gw ^ pat[5-s];
                sb_q.push_back(e);
            end
        end
        e.tx = gw;
        for (int c = 0; c < GAP - 1; c++) sb_q.push_back(e);
    endtask

    task automatic push_idle(input logic gw, input int n);
        exp_t e;
        e.tx   = gw;
        e.busy = 1'b0;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("tx", int'(o_hv_pwm_tx), int'(e.tx));
                chk("busy", int'(o_busy), int'(e.busy));
            end
            if (o_flt_ack) ack_cnt++;
            if (o_flt_ovr) ovr_cnt++;
            i_intb_req = 1'b0;
            i_wdg_req  = 1'b0;
            i_flt_req  = 1'b0;
        end
    endtask

    task automatic run_all();
        while (sb_q.size() > 0) run(1);
    endtask

    initial begin
        logic [3:0] pt_pat;
        i_rst_n        = 1'b0;
        i_hv_pwm_gwave = 1'b0;
        i_intb_req     = 1'b0;
        i_intb_lvl     = 1'b0;
        i_wdg_req      = 1'b0;
        i_flt_req      = 1'b0;
        i_flt_code     = 3'b000;
        repeat (2) @(negedge i_clk);
        chk("rst_tx", int'(o_hv_pwm_tx), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ack", int'(o_flt_ack), 0);
        chk("rst_ovr", int'(o_flt_ovr), 0);
        i_rst_n = 1'b1;
        run(1);

        // Idle pass-through of the gate wave.
        pt_pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            i_hv_pwm_gwave = pt_pat[i];
            push_idle(pt_pat[i], 1);
            run(1);
        end

        // INTB lvl=1 on gwave=0.
        ack_cnt = 0;
        i_hv_pwm_gwave = 1'b0;
        i_intb_req = 1'b1;
        i_intb_lvl = 1'b1;
        push_frame(1'b0, 6'b101000, 3);
        push_idle(1'b0, 2);
        run_all();
        chk("intb1_ack_cnt", ack_cnt, 0);

        // Fault code 101 on gwave=1.
        ack_cnt = 0;
        i_hv_pwm_gwave = 1'b1;
        i_flt_req  = 1'b1;
        i_flt_code = 3'b101;
        push_frame(1'b1, 6'b101010, 6);
        push_idle(1'b1, 2);
        run_all();
        chk("flt_ack_cnt", ack_cnt, 1);

        // Same-cycle INTB and fault: INTB first, fault right after the gap.
        ack_cnt = 0;
        i_hv_pwm_gwave = 1'b0;
        i_intb_req = 1'b1;
        i_intb_lvl = 1'b1;
        i_flt_req  = 1'b1;
        i_flt_code = 3'b011;
        push_frame(1'b0, 6'b101000, 3);
        push_frame(1'b0, flt_pat(3'b011), 6);
        push_idle(1'b0, 2);
        run_all();
        chk("prio_ack_cnt", ack_cnt, 1);

        // Two fault requests during an INTB lvl=0 frame: one overwrite, newest code sent.
        ack_cnt = 0;
        ovr_cnt = 0;
        i_intb_req = 1'b1;
        i_intb_lvl = 1'b0;
        push_frame(1'b0, 6'b100000, 1);
        push_frame(1'b0, flt_pat(3'b110), 6);
        push_idle(1'b0, 2);
        run(5);
        i_flt_req  = 1'b1;
        i_flt_code = 3'b001;
        run(2);
        i_flt_req  = 1'b1;
        i_flt_code = 3'b110;
        run_all();
        chk("ovr_cnt", ovr_cnt, 1);
        chk("ovr_ack_cnt", ack_cnt, 1);

        // Watchdog resends last level (0) as a single symbol inverted against g_lock=1.
        i_hv_pwm_gwave = 1'b1;
        i_wdg_req = 1'b1;
        push_frame(1'b1, 6'b100000, 1);
        push_idle(1'b1, 2);
        run_all();

        // Reset during the second symbol of a fault frame.
        ack_cnt = 0;
        i_hv_pwm_gwave = 1'b0;
        i_flt_req  = 1'b1;
        i_flt_code = 3'b111;
        push_frame(1'b0, flt_pat(3'b111), 6);
        run(13);
        i_rst_n = 1'b0;
        sb_q.delete();
        @(negedge i_clk);
        chk("midrst_tx", int'(o_hv_pwm_tx), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_ack", int'(o_flt_ack), 0);
        i_rst_n = 1'b1;
        push_idle(1'b0, 1);
        run(1);
        chk("midrst_ack_cnt", ack_cnt, 0);

        // Clean frame after reset.
        i_hv_pwm_gwave = 1'b1;
        i_intb_req = 1'b1;
        i_intb_lvl = 1'b1;
        push_frame(1'b1, 6'b101000, 3);
        push_idle(1'b1, 2);
        run_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
